// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and helpers for the chunk-serial adder.
// State encoding, default geometry and index-width helper.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int N_CHUNKS  = DEF_WIDTH / DEF_CHUNK;

    // Index width for n chunks; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder used once per cycle by the top.
// Exposes the carry into the top bit so the caller can form signed overflow.
module chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: one CHUNK-wide slice per clock, carry held in a register.
// Valid/ready on both sides; result registers hold until the next acceptance.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IW    = clog2(N);
    localparam int SLOTS = 1 << IW;

    if (WIDTH % CHUNK != 0) begin : g_bad_geometry
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             last;

    logic [CHUNK-1:0] a_sl [SLOTS];
    logic [CHUNK-1:0] b_sl [SLOTS];
    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;

    // Pad the slice table to a power of two so idx indexes it exactly.
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slice
        if (gi < N) begin : g_used
            assign a_sl[gi] = op_a[gi*CHUNK +: CHUNK];
            assign b_sl[gi] = op_b[gi*CHUNK +: CHUNK];
        end else begin : g_pad
            assign a_sl[gi] = '0;
            assign b_sl[gi] = '0;
        end
    end

    assign x    = a_sl[idx];
    assign y    = b_sl[idx];
    assign last = (idx == IW'(N - 1));

    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x    (x),
        .y    (y),
        .ci   (carry),
        .s    (s),
        .co   (co),
        .c_msb(c_msb)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                if (idx == IW'(i)) sum[i*CHUNK +: CHUNK] <= s;
            end
            carry <= co;
            if (last) begin
                cout     <= co;
                overflow <= c_msb ^ co;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: 16/4 instance checked against an arithmetic
// model every cycle, plus directed literals and an 8/8 single-chunk instance.
module tb_seq_chunk_adder;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    logic         v8 = 1'b0;
    logic         r8;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         c8 = 1'b0;
    logic         ov8;
    logic         or8 = 1'b0;
    logic [7:0]   s8;
    logic         co8;
    logic         of8;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(c8),
        .out_valid(ov8), .out_ready(or8),
        .sum(s8), .cout(co8), .overflow(of8)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } res_t;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
        logic [W:0] t;
        res_t r;
        t = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    res_t q[$];
    res_t last_res;
    bit   busy = 0;
    bit   have_last = 0;
    bit   seen_valid = 0;
    int   acc_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            busy = 0;
            have_last = 0;
            seen_valid = 0;
        end else begin
            check("mon_in_ready", 32'(in_ready), 32'(!busy));
            if (!busy) check("mon_idle_no_valid", 32'(out_valid), 32'd0);
            if (out_valid && q.size() > 0) begin
                check("mon_sum", 32'(sum), 32'(q[0].s));
                check("mon_cout", 32'(cout), 32'(q[0].c));
                check("mon_ovf", 32'(overflow), 32'(q[0].o));
                if (!seen_valid) begin
                    check("mon_latency", 32'(cyc), 32'(acc_cyc + NC + 1));
                    seen_valid = 1;
                end
                if (out_ready) begin
                    last_res = q.pop_front();
                    have_last = 1;
                    busy = 0;
                    seen_valid = 0;
                end
            end else if (have_last && !busy) begin
                check("mon_hold_sum", 32'(sum), 32'(last_res.s));
                check("mon_hold_cout", 32'(cout), 32'(last_res.c));
                check("mon_hold_ovf", 32'(overflow), 32'(last_res.o));
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                busy = 1;
                acc_cyc = cyc;
            end
        end
    end

    task automatic op16(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input bit lit,
                        input logic [W-1:0] es, input logic ec,
                        input logic eo, input int hold, input bit toggle);
        int it;
        bit got;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 0;
        it = 0;
        while (!got && it < 40) begin
            @(posedge clk); #1;
            it++;
            if (toggle) begin
                in_valid = ~in_valid;
                a = 16'h1234;
                b = 16'h1111;
            end
            @(negedge clk);
            got = out_valid;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency_iters", 32'(it), 32'(NC));
        if (lit) begin
            check("lit_sum", 32'(sum), 32'(es));
            check("lit_cout", 32'(cout), 32'(ec));
            check("lit_ovf", 32'(overflow), 32'(eo));
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            if (lit) begin
                check("bp_sum", 32'(sum), 32'(es));
                check("bp_cout", 32'(cout), 32'(ec));
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int it;
        bit got;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        op16(16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 1'b0, 1'b0, 0, 0);
        op16(16'hFFFF, 16'h0001, 1'b0, 1, 16'h0000, 1'b1, 1'b0, 3, 0);
        op16(16'h7FFF, 16'h0000, 1'b1, 1, 16'h8000, 1'b0, 1'b1, 0, 0);
        op16(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1, 0, 0);
        op16(16'h0001, 16'h0002, 1'b0, 1, 16'h0003, 1'b0, 1'b0, 0, 1);
        op16(16'h1234, 16'hEDCB, 1'b1, 1, 16'h0000, 1'b1, 1'b0, 1, 0);
        op16(16'h4000, 16'h4000, 1'b0, 1, 16'h8000, 1'b0, 1'b1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 0,
                 16'h0, 1'b0, 1'b0, k % 2, 0);
        end

        // Abort an operation in its second RUN cycle.
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        op16(16'h0005, 16'h0003, 1'b0, 1, 16'h0008, 1'b0, 1'b0, 0, 0);

        // Single-chunk instance: result one cycle after the lone RUN cycle.
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        check("n1_accept_ready", 32'(r8), 32'd1);
        @(posedge clk); #1;
        v8 = 1'b0;
        got = 0;
        it = 0;
        while (!got && it < 20) begin
            @(posedge clk); #1;
            it++;
            @(negedge clk);
            got = ov8;
        end
        check("n1_done_seen", 32'(got), 32'd1);
        check("n1_latency_iters", 32'(it), 32'd1);
        check("n1_sum", 32'(s8), 32'h00);
        check("n1_cout", 32'(co8), 32'd1);
        check("n1_ovf", 32'(of8), 32'd1);
        @(posedge clk); #1;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        check("n1_post_in_ready", 32'(r8), 32'd1);
        check("n1_post_out_valid", 32'(ov8), 32'd0);
        check("n1_hold_sum", 32'(s8), 32'h00);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
